// File: rtl/lfsr_domain_xfer_if.sv
// lfsr_domain_xfer_if: advance enable in, raw LFSR state and filtered data out
interface lfsr_domain_xfer_if #(parameter int WIDTH = 5);
  logic en;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] d;
  logic d_valid;
  modport master (input en, output lfsr, d, d_valid);
  modport slave (output en, input lfsr, d, d_valid);
endinterface

// File: rtl/lfsr_domain_xfer.sv
// lfsr_domain_xfer: slow-ticked Fibonacci LFSR with 2-flop re-timing and stability filter
module lfsr_domain_xfer #(
  parameter int WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(5'b10100),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(5'b00001),
  parameter int SLOW_DIV = 2
) (
  input logic clk,
  input logic rst,
  lfsr_domain_xfer_if.master bus
);
  logic [7:0] cnt;
  logic [WIDTH-1:0] lfsr, lfsr_next, s1, s2, d;
  logic d_valid, tick, stable;
  always_comb begin
    tick = bus.en && cnt == 8'(SLOW_DIV - 1);
    lfsr_next = lfsr == '0 ? SEED : {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    stable = s1 == s2 && s2 != d;
  end
  // d only ever copies a value seen on two consecutive samples, so it never shows a transient
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      lfsr <= SEED;
      s1 <= SEED;
      s2 <= SEED;
      d <= SEED;
      d_valid <= 1'b0;
    end else begin
      if (bus.en) cnt <= tick ? '0 : cnt + 8'd1;
      if (tick) lfsr <= lfsr_next;
      s1 <= lfsr;
      s2 <= s1;
      d_valid <= stable;
      if (stable) d <= s2;
    end
  assign bus.lfsr = lfsr;
  assign bus.d = d;
  assign bus.d_valid = d_valid;
endmodule

// File: tb/tb_lfsr_domain_xfer.sv
// tb_lfsr_domain_xfer: directed checks of sequence, latency, period, enable freeze and reset
module tb_lfsr_domain_xfer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [4:0] seq [0:30] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B, 5'h16,
                             5'h0C, 5'h19, 5'h13, 5'h07, 5'h0F, 5'h1F, 5'h1E, 5'h1C,
                             5'h18, 5'h11, 5'h03, 5'h06, 5'h0D, 5'h1B, 5'h17, 5'h0E,
                             5'h1D, 5'h1A, 5'h15, 5'h0A, 5'h14, 5'h08, 5'h10};
  lfsr_domain_xfer_if #(.WIDTH(5)) bus ();
  lfsr_domain_xfer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    edge_step();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    edge_step();
    edge_step();
    vectors++;
    if (bus.lfsr !== 5'h01) begin miscompares++; $display("FAIL reset_lfsr: got %h expected 01", bus.lfsr); end
    vectors++;
    if (bus.d !== 5'h01) begin miscompares++; $display("FAIL reset_d: got %h expected 01", bus.d); end
    vectors++;
    if (bus.d_valid !== 1'b0) begin miscompares++; $display("FAIL reset_d_valid: got %b expected 0", bus.d_valid); end
  endtask
  task automatic test_sequence();
    rst = 1'b0;
    bus.en = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      edge_step();
      vectors++;
      if (bus.lfsr !== seq[e / 2]) begin miscompares++; $display("FAIL sequence edge %0d: got %h expected %h", e, bus.lfsr, seq[e / 2]); end
    end
  endtask
  task automatic test_latency();
    bus.en = 1'b1;
    do_reset();
    edge_step();
    edge_step();
    vectors++;
    if (bus.lfsr !== 5'h02) begin miscompares++; $display("FAIL latency_step N: got %h expected 02", bus.lfsr); end
    edge_step();
    vectors++;
    if (bus.d !== 5'h01 || bus.d_valid !== 1'b0) begin miscompares++; $display("FAIL latency N+1: got d=%h v=%b expected d=01 v=0", bus.d, bus.d_valid); end
    edge_step();
    vectors++;
    if (bus.d !== 5'h01 || bus.d_valid !== 1'b0) begin miscompares++; $display("FAIL latency N+2: got d=%h v=%b expected d=01 v=0", bus.d, bus.d_valid); end
    edge_step();
    vectors++;
    if (bus.d !== 5'h02 || bus.d_valid !== 1'b1) begin miscompares++; $display("FAIL latency N+3: got d=%h v=%b expected d=02 v=1", bus.d, bus.d_valid); end
    edge_step();
    vectors++;
    if (bus.d !== 5'h02 || bus.d_valid !== 1'b0) begin miscompares++; $display("FAIL latency N+4: got d=%h v=%b expected d=02 v=0", bus.d, bus.d_valid); end
  endtask
  task automatic test_period();
    int pulses = 0;
    logic prev = 1'b0;
    bus.en = 1'b1;
    do_reset();
    for (int e = 1; e <= 124; e++) begin
      edge_step();
      if (bus.d_valid === 1'b1) begin
        pulses++;
        vectors++;
        if (bus.d !== seq[pulses % 31]) begin miscompares++; $display("FAIL period_d pulse %0d: got %h expected %h", pulses, bus.d, seq[pulses % 31]); end
      end
      vectors++;
      if (prev === 1'b1 && bus.d_valid === 1'b1) begin miscompares++; $display("FAIL back_to_back edge %0d: got d_valid=1 twice expected single pulse", e); end
      prev = bus.d_valid;
      if (e % 2 == 0) begin
        vectors++;
        if (bus.lfsr !== seq[(e / 2) % 31]) begin miscompares++; $display("FAIL period tick %0d: got %h expected %h", e / 2, bus.lfsr, seq[(e / 2) % 31]); end
      end
    end
    vectors++;
    if (pulses != 60) begin miscompares++; $display("FAIL period_pulse_count: got %0d expected 60", pulses); end
  endtask
  task automatic test_enable();
    bus.en = 1'b1;
    do_reset();
    for (int e = 1; e <= 7; e++) edge_step();
    vectors++;
    if (bus.lfsr !== 5'h09) begin miscompares++; $display("FAIL enable_pre: got %h expected 09", bus.lfsr); end
    bus.en = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      edge_step();
      vectors++;
      if (bus.lfsr !== 5'h09) begin miscompares++; $display("FAIL enable_freeze_lfsr %0d: got %h expected 09", e, bus.lfsr); end
      vectors++;
      if (bus.d_valid !== (e == 2)) begin miscompares++; $display("FAIL enable_freeze_valid %0d: got %b expected %b", e, bus.d_valid, e == 2); end
      if (e >= 2) begin
        vectors++;
        if (bus.d !== 5'h09) begin miscompares++; $display("FAIL enable_freeze_d %0d: got %h expected 09", e, bus.d); end
      end
    end
    bus.en = 1'b1;
    edge_step();
    vectors++;
    if (bus.lfsr !== 5'h12) begin miscompares++; $display("FAIL enable_resume_1: got %h expected 12", bus.lfsr); end
    edge_step();
    edge_step();
    vectors++;
    if (bus.lfsr !== 5'h05) begin miscompares++; $display("FAIL enable_resume_3: got %h expected 05", bus.lfsr); end
    edge_step();
    vectors++;
    if (bus.d !== 5'h12 || bus.d_valid !== 1'b1) begin miscompares++; $display("FAIL enable_resume_d: got d=%h v=%b expected d=12 v=1", bus.d, bus.d_valid); end
  endtask
  task automatic test_reset_mid();
    bus.en = 1'b1;
    do_reset();
    for (int e = 1; e <= 8; e++) edge_step();
    vectors++;
    if (bus.lfsr !== 5'h12) begin miscompares++; $display("FAIL reset_mid_pre: got %h expected 12", bus.lfsr); end
    rst = 1'b1;
    edge_step();
    vectors++;
    if (bus.lfsr !== 5'h01 || bus.d !== 5'h01 || bus.d_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mid: got lfsr=%h d=%h v=%b expected 01 01 0", bus.lfsr, bus.d, bus.d_valid); end
    rst = 1'b0;
    edge_step();
    edge_step();
    vectors++;
    if (bus.lfsr !== 5'h02) begin miscompares++; $display("FAIL reset_mid_restart: got %h expected 02", bus.lfsr); end
    edge_step();
    edge_step();
    edge_step();
    vectors++;
    if (bus.d !== 5'h02 || bus.d_valid !== 1'b1) begin miscompares++; $display("FAIL reset_mid_d: got d=%h v=%b expected d=02 v=1", bus.d, bus.d_valid); end
  endtask
  initial begin
    bus.en = 1'b0;
    test_reset();
    test_sequence();
    test_latency();
    test_period();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
